seq_scan_ctrl: RTL and testbench

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_ctrl_pkg.sv | 16 +
 rtl/seq_match_core.sv | 46 ++++
 rtl/seq_scan_ctrl.sv | 108 ++++++++++
 tb/tb_seq_scan_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_ctrl_pkg.sv
// Shared definitions for the serial pattern scanner: FSM state encoding and
// the width helper used for bit and match counters.
package seq_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      DONE = 2'b10
   } state_t;

   // Bits needed to hold any value 0..n.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// Pattern window for the serial scanner: history shift register, saturating
// fill counter and the combinational match compare.
module seq_match_core
   import seq_scan_ctrl_pkg::*;
#(
   parameter int PAT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift,
   input  logic             serial,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   output logic             match
);

   localparam int FW = cnt_w(PAT_W);

   logic [PAT_W-1:0] history;
   logic [FW-1:0]    fill;
   logic [PAT_W-1:0] window;

   // The newest PAT_W bits including the one on the line this cycle.
   assign window = PAT_W'({history, serial});

   assign match = shift && ((int'(fill) + 1) >= PAT_W) && (window == pattern);

   // NOTE: reset is sampled on the clock edge and takes priority over every other update.
   always_ff @(posedge clk) begin
      if (!rst) begin
         history <= '0;
         fill    <= '0;
      end else if (clear) begin
         history <= '0;
         fill    <= '0;
      end else if (shift) begin
         history <= window;
         if (match && !overlap)
            fill <= '0;
         else if (fill != FW'(PAT_W))
            fill <= fill + 1'b1;
      end
   end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serial scanner: captures a word, shifts it out MSB first and counts
// occurrences of a programmable pattern, overlapping or not.
module seq_scan_ctrl
   import seq_scan_ctrl_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int PAT_W  = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [DATA_W-1:0]        data_in,
   input  logic [PAT_W-1:0]         pattern,
   input  logic                     overlap,
   output logic                     busy,
   output logic                     bit_out,
   output logic                     match,
   output logic [cnt_w(DATA_W)-1:0] match_count,
   output logic                     done
);

   localparam int CW = cnt_w(DATA_W);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] shreg;
   logic [PAT_W-1:0]  pat_q;
   logic              ov_q;
   logic [CW-1:0]     bit_cnt;
   logic              accept;
   logic              scanning;
   logic              last_bit;

   assign accept   = (state == IDLE) && start;
   assign scanning = rst && (state == SCAN);
   assign last_bit = (bit_cnt == CW'(DATA_W - 1));
   assign bit_out  = scanning && shreg[DATA_W-1];

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_nxt = SCAN;
         end
         SCAN: begin
            busy = 1'b1;
            if (last_bit)
               state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Outputs stay quiet for the whole time reset is asserted.
      if (!rst) begin
         busy = 1'b0;
         done = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg       <= '0;
         pat_q       <= '0;
         ov_q        <= 1'b0;
         bit_cnt     <= '0;
         match_count <= '0;
      end else if (accept) begin
         shreg       <= data_in;
         pat_q       <= pattern;
         ov_q        <= overlap;
         bit_cnt     <= '0;
         match_count <= '0;
      end else if (state == SCAN) begin
         shreg   <= shreg << 1;
         bit_cnt <= bit_cnt + 1'b1;
         if (match)
            match_count <= match_count + 1'b1;
      end
   end

   seq_match_core #(
      .PAT_W (PAT_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept),
      .shift   (scanning),
      .serial  (bit_out),
      .pattern (pat_q),
      .overlap (ov_q),
      .match   (match)
   );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: directed vector table, hand-built abort/ignore
// sequences, randomized scans against a window-search model, short-word case.
module tb_seq_scan_ctrl;
   import seq_scan_ctrl_pkg::*;

   localparam int DATA_W = 16;
   localparam int PAT_W  = 5;
   localparam int CW     = cnt_w(DATA_W);

   logic              clk     = 1'b0;
   logic              rst     = 1'b0;
   logic              start   = 1'b0;
   logic              overlap = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic [PAT_W-1:0]  pattern = '0;
   logic              busy, bit_out, match, done;
   logic [CW-1:0]     match_count;

   // Second instance with a pattern longer than the word.
   logic       start2 = 1'b0;
   logic [3:0] data2  = '0;
   logic       busy2, bit2, match2, done2;
   logic [2:0] count2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .pattern(pattern),
      .overlap(overlap), .busy(busy), .bit_out(bit_out), .match(match),
      .match_count(match_count), .done(done)
   );

   seq_scan_ctrl #(.DATA_W(4), .PAT_W(5)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .data_in(data2), .pattern(pattern),
      .overlap(overlap), .busy(busy2), .bit_out(bit2), .match(match2),
      .match_count(count2), .done(done2)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected matches found by sliding a PAT_W window over the bit string;
   // non-overlapping mode only accepts a window starting after the last match.
   function automatic void model(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p,
                                 input logic ov, output logic [DATA_W-1:0] mask,
                                 output int cnt);
      int               last_end;
      logic [PAT_W-1:0] w;
      last_end = 0;
      mask     = '0;
      cnt      = 0;
      for (int i = PAT_W; i <= DATA_W; i++) begin
         w = d[DATA_W-i +: PAT_W];
         if (w == p && (ov || (i - PAT_W) >= last_end)) begin
            mask[i-1] = 1'b1;
            cnt++;
            last_end = i;
         end
      end
   endfunction

   // Runs one scan from IDLE; cycle k is the k-th cycle after the accepting edge.
   task automatic run_scan(input string tag, input logic [DATA_W-1:0] d,
                           input logic [PAT_W-1:0] p, input logic ov,
                           input logic [DATA_W-1:0] exp_mask, input int exp_cnt,
                           input int poke_cycle, input int rst_cycle);
      int n_done;
      int so_far;
      start   = 1'b1;
      data_in = d;
      pattern = p;
      overlap = ov;
      tick();
      start   = 1'b0;
      data_in = ~d;
      pattern = ~p;
      overlap = ~ov;
      n_done  = 0;
      so_far  = 0;
      for (int k = 1; k <= DATA_W + 1; k++) begin
         check($sformatf("%s c%0d busy", tag, k), int'(busy), 1);
         check($sformatf("%s c%0d bit_out", tag, k), int'(bit_out),
               (k <= DATA_W) ? int'(d[DATA_W-k]) : 0);
         check($sformatf("%s c%0d match", tag, k), int'(match),
               (k <= DATA_W) ? int'(exp_mask[k-1]) : 0);
         check($sformatf("%s c%0d done", tag, k), int'(done), (k == DATA_W + 1) ? 1 : 0);
         check($sformatf("%s c%0d match_count", tag, k), int'(match_count), so_far);
         if (done) n_done++;
         if (k <= DATA_W && exp_mask[k-1]) so_far++;
         start = (k == poke_cycle);
         if (k == rst_cycle) begin
            rst   = 1'b0;
            start = 1'b1;
            tick();
            rst   = 1'b1;
            start = 1'b0;
            check($sformatf("%s abort busy", tag), int'(busy), 0);
            check($sformatf("%s abort match_count", tag), int'(match_count), 0);
            check($sformatf("%s abort done", tag), int'(done), 0);
            check($sformatf("%s abort bit_out", tag), int'(bit_out), 0);
            tick();
            check($sformatf("%s abort idle busy", tag), int'(busy), 0);
            check($sformatf("%s abort idle done", tag), int'(done), 0);
            return;
         end
         tick();
      end
      check($sformatf("%s done pulses", tag), n_done, 1);
      check($sformatf("%s idle busy", tag), int'(busy), 0);
      check($sformatf("%s final count", tag), int'(match_count), exp_cnt);
      tick();
      check($sformatf("%s held count", tag), int'(match_count), exp_cnt);
      check($sformatf("%s held done", tag), int'(done), 0);
   endtask

   typedef struct {
      logic [DATA_W-1:0] d;
      logic [PAT_W-1:0]  p;
      logic              ov;
      logic [DATA_W-1:0] mask;
      int                cnt;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [DATA_W-1:0] rd, rmask;
      logic [PAT_W-1:0]  rp;
      logic              rov;
      int                rcnt;
      int                pos;

      vecs[0] = '{16'hB000, 5'b10110, 1'b1, 16'h0010, 1};
      vecs[1] = '{16'hB6C0, 5'b10110, 1'b1, 16'h0490, 3};
      vecs[2] = '{16'hB6C0, 5'b10110, 1'b0, 16'h0410, 2};
      vecs[3] = '{16'h0000, 5'b00000, 1'b1, 16'hFFF0, 12};
      vecs[4] = '{16'h0000, 5'b00000, 1'b0, 16'h4210, 3};
      vecs[5] = '{16'hFFFF, 5'b11111, 1'b0, 16'h4210, 3};
      vecs[6] = '{16'h0000, 5'b10110, 1'b1, 16'h0000, 0};
      vecs[7] = '{16'h0016, 5'b10110, 1'b1, 16'h8000, 1};

      tick();
      tick();
      check("reset busy", int'(busy), 0);
      check("reset bit_out", int'(bit_out), 0);
      check("reset match", int'(match), 0);
      check("reset done", int'(done), 0);
      check("reset match_count", int'(match_count), 0);
      rst = 1'b1;
      tick();
      check("post-reset busy", int'(busy), 0);
      check("post-reset match_count", int'(match_count), 0);

      foreach (vecs[i])
         run_scan($sformatf("vec%0d", i), vecs[i].d, vecs[i].p, vecs[i].ov,
                  vecs[i].mask, vecs[i].cnt, -1, -1);

      run_scan("poke", 16'hB6C0, 5'b10110, 1'b1, 16'h0490, 3, 4, -1);
      run_scan("abort", 16'hB6C0, 5'b10110, 1'b1, 16'h0490, 3, -1, 6);
      run_scan("after_abort", 16'hB6C0, 5'b10110, 1'b0, 16'h0410, 2, -1, -1);

      for (int n = 0; n < 24; n++) begin
         rd = DATA_W'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            pos = $urandom_range(0, DATA_W - PAT_W);
            rp  = rd[pos +: PAT_W];
         end else begin
            rp = PAT_W'($urandom);
         end
         rov = 1'($urandom_range(0, 1));
         model(rd, rp, rov, rmask, rcnt);
         run_scan($sformatf("rnd%0d", n), rd, rp, rov, rmask, rcnt, -1, -1);
      end

      pattern = '0;
      overlap = 1'b1;
      data2   = 4'h0;
      start2  = 1'b1;
      tick();
      start2 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         check($sformatf("short c%0d busy", k), int'(busy2), 1);
         check($sformatf("short c%0d bit", k), int'(bit2), 0);
         check($sformatf("short c%0d match", k), int'(match2), 0);
         check($sformatf("short c%0d done", k), int'(done2), (k == 5) ? 1 : 0);
         tick();
      end
      check("short idle busy", int'(busy2), 0);
      check("short count", int'(count2), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
